round_key_bank_dbuf: RTL and testbench
======================================

// Module: round_key_bank_dbuf
// PURPOSE
//  Double-buffered store for the expanded AES key. Sits directly downstream of the sequential key scheduler.
//  Captures the full round-key vector when the scheduler's output-ready pulse arrives.
//  Serves one 128-bit round key per cycle to the iterative cipher core, indexed by round number.
//  A new key goes live only at a block boundary, so a block in flight never mixes keys.
// PARAMETERS
//  NB_BYTE        8   bits per byte
//  N_BYTES_STATE  16  bytes per round key
//  N_ROUNDS       14  cipher rounds; N_ROUNDS+1 round keys stored per bank
//  NB_ROUND_IDX   4   round-index width; must satisfy 2**NB_ROUND_IDX > N_ROUNDS
// PORTS
//  i_clock             in   1       single clock
//  i_reset_n           in   1       async active-low reset
//  i_round_key_vector  in   NB_RK*(N_ROUNDS+1)  round-key vector from scheduler; slice k = round k; slice 0 in LSBs
//  i_key_ready         in   1       one-cycle pulse: vector complete (scheduler output-ready)
//  i_valid             in   1       clock enable; every state update is qualified by it
//  i_flush             in   1       sync clear of both banks' valid flags
//  i_block_start       in   1       cipher starts a new block this cycle; swap allowed
//  i_round_index       in   NB_ROUND_IDX  round key requested
//  o_round_key         out  NB_RK   registered round key (NB_RK = N_BYTES_STATE*NB_BYTE)
//  o_key_valid         out  1       active bank holds a valid key
//  o_shadow_full       out  1       shadow bank holds a key waiting for a swap
//  o_overwrite         out  1       pulse: an unswapped shadow key was replaced
//  o_index_error       out  1       pulse: i_round_index > N_ROUNDS
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low.
//  - Reset values:
//    - o_round_key = 0; all flags = 0; bank pointer ptr = 0.
//    - Bank contents are not reset.
//  - Banks and pointers:
//    - Two banks A/B. ptr selects the active bank; the shadow bank is ~ptr.
//    - Swap = toggle ptr. Bank data is never copied.
//  - Swap condition, evaluated with i_valid=1:
//    - shadow_full AND (!active_valid OR i_block_start).
//    - On swap: active_valid <= 1, shadow_full <= 0.
//  - Capture (i_valid & i_key_ready):
//    - Writes the vector into bank ~ptr_next, where ptr_next is ptr after this edge's swap.
//    - Sets shadow_full <= 1.
//    - If shadow_full was 1 and no swap occurs this cycle: o_overwrite = 1 for one cycle. Newest key wins.
//  - Capture and swap in the same cycle: the old shadow becomes active, the new vector fills the freed bank, shadow_full stays 1.
//  - Cold start: after reset or flush, the first captured key goes live on the next valid cycle without waiting for i_block_start.
//  - Readout, latency 1:
//    - On i_valid: o_round_key <= bank[ptr_next][i_round_index].
//    - Reading through ptr_next means the block whose i_block_start triggers the swap gets the new key for every round, including round 0.
//    - If !active_valid after the edge: o_round_key <= 0.
//  - Out-of-range index: i_round_index > N_ROUNDS gives o_round_key <= 0 and o_index_error = 1 for one cycle. State is unaffected.
//  - i_valid = 0: all registers hold, including o_round_key; pulse outputs drop to 0.
//  - i_flush (i_valid=1): active_valid <= 0, shadow_full <= 0, o_round_key <= 0.
//    - Flush has priority over capture and swap in the same cycle.
//  - Reset mid-operation: immediate clear as above. A new key must be captured afterwards.
// STRUCTURE
//  - Shared package aes_key_pkg:
//    - NB_BYTE, N_BYTES_STATE, NB_RK, N_ROUNDS_AES256=14, N_ROUNDS_AES128=10.
//    - NB_ROUND_IDX derivation, slice-offset function rk_slice(k).
//  - Sub-module round_key_bank_selector (combinational): bank select, index slice, range check, zero-force.
//  - Top level holds the banks, ptr, flags and output register.
// TESTING
//  1 Cold start:
//    - Stimulus: after reset, capture vector V1 with slice k = {16{8'(k)}}.
//    - Response: o_key_valid=1 two valid cycles later; idx=5 -> next cycle o_round_key=128'h0505..05.
//  2 Shadow load mid-block:
//    - Stimulus: capture V2 (slice k = {16{8'h80|k}}) while streaming; idx=3.
//    - Response: output stays 0x0303..03. Then i_block_start with idx=0 -> next cycle 0x8080..80.
//  3 Double capture:
//    - Stimulus: V2 then V3 (slice k = {16{8'h40|k}}), no block start.
//    - Response: o_overwrite=1 on the second capture; after swap, idx=14 -> 0x4E4E..4E.
//  4 Same-cycle capture and swap:
//    - Stimulus: i_block_start and i_key_ready (V3) in one cycle with V2 shadowed.
//    - Response: active=V2, o_shadow_full=1; next block start -> V3.
//  5 Edge cases:
//    - idx=15 -> o_round_key=0, o_index_error=1 for exactly one cycle.
//    - i_valid=0 for 5 cycles -> outputs frozen, no pulses.
//  6 Flush and reset:
//    - i_flush -> o_key_valid=0, o_shadow_full=0, o_round_key=0.
//    - Async i_reset_n low mid-block -> all outputs 0 before the next clock edge; recovery via scenario 1.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared AES key-path constants and the round-key slice helper used by the key bank.
package aes_key_pkg;

  localparam int unsigned NB_BYTE         = 8;
  localparam int unsigned N_BYTES_STATE   = 16;
  localparam int unsigned NB_RK           = N_BYTES_STATE * NB_BYTE;
  localparam int unsigned N_ROUNDS_AES256 = 14;
  localparam int unsigned N_ROUNDS_AES128 = 10;
  localparam int unsigned N_ROUNDS        = N_ROUNDS_AES256;
  localparam int unsigned NB_ROUND_IDX    = $clog2(N_ROUNDS + 1);
  localparam int unsigned NB_RK_VEC       = NB_RK * (N_ROUNDS + 1);

  localparam logic [NB_ROUND_IDX-1:0] LAST_ROUND_IDX = NB_ROUND_IDX'(N_ROUNDS);

  // Bit offset of round key k inside the packed vector (round 0 in the LSBs).
  function automatic int unsigned rk_slice(input int unsigned k);
    return k * NB_RK;
  endfunction

endpackage

// File: rtl/round_key_bank_selector.sv
// Combinational read path: picks a bank, slices one round key, range-checks the index
// and forces zero when the key is not live or the index is out of range.
module round_key_bank_selector
  import aes_key_pkg::*;
(
  input  logic [NB_RK_VEC-1:0]    i_bank_a,
  input  logic [NB_RK_VEC-1:0]    i_bank_b,
  input  logic                    i_sel,
  input  logic                    i_enable,
  input  logic [NB_ROUND_IDX-1:0] i_round_index,
  output logic [NB_RK-1:0]        o_round_key,
  output logic                    o_index_error
);

  logic [NB_RK_VEC-1:0]    bank_s;
  logic [NB_RK-1:0]        keys_s [N_ROUNDS+1];
  logic [NB_ROUND_IDX-1:0] idx_safe_s;

  // Bank select: 1 picks bank B.
  always_comb begin
    if (i_sel) begin
      bank_s = i_bank_b;
    end else begin
      bank_s = i_bank_a;
    end
  end

  for (genvar k = 0; k <= int'(N_ROUNDS); k++) begin : g_slice
    assign keys_s[k] = bank_s[rk_slice(k) +: NB_RK];
  end

  // Range check; the index is clamped so the array read never leaves its bounds.
  always_comb begin
    o_index_error = (i_round_index > LAST_ROUND_IDX);
    if (o_index_error) begin
      idx_safe_s = {NB_ROUND_IDX{1'b0}};
    end else begin
      idx_safe_s = i_round_index;
    end
    if (i_enable && !o_index_error) begin
      o_round_key = keys_s[idx_safe_s];
    end else begin
      o_round_key = {NB_RK{1'b0}};
    end
  end

endmodule

// File: rtl/round_key_bank_dbuf.sv
// Double-buffered expanded-key store: captures scheduler output into the shadow bank
// and makes it live only at a block boundary (or immediately on cold start).
module round_key_bank_dbuf
  import aes_key_pkg::*;
(
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [NB_RK_VEC-1:0]    i_round_key_vector,
  input  logic                    i_key_ready,
  input  logic                    i_valid,
  input  logic                    i_flush,
  input  logic                    i_block_start,
  input  logic [NB_ROUND_IDX-1:0] i_round_index,
  output logic [NB_RK-1:0]        o_round_key,
  output logic                    o_key_valid,
  output logic                    o_shadow_full,
  output logic                    o_overwrite,
  output logic                    o_index_error
);

  logic                 ptr_q, ptr_d;
  logic                 active_valid_q, active_valid_d;
  logic                 shadow_full_q, shadow_full_d;
  logic                 overwrite_q, overwrite_d;
  logic                 index_error_q, index_error_d;
  logic [NB_RK-1:0]     round_key_q, round_key_d;
  logic [NB_RK_VEC-1:0] bank_a_q, bank_b_q;
  logic                 swap_s, capture_s;
  logic [NB_RK-1:0]     sel_key_s;
  logic                 sel_range_err_s;

  // Read through ptr_d so a block whose start triggers the swap sees the new key from round 0.
  round_key_bank_selector u_selector (
    .i_bank_a      (bank_a_q),
    .i_bank_b      (bank_b_q),
    .i_sel         (ptr_d),
    .i_enable      (active_valid_d),
    .i_round_index (i_round_index),
    .o_round_key   (sel_key_s),
    .o_index_error (sel_range_err_s)
  );

  // Next-state logic: flush outranks swap and capture.
  always_comb begin
    ptr_d          = ptr_q;
    active_valid_d = active_valid_q;
    shadow_full_d  = shadow_full_q;
    overwrite_d    = 1'b0;
    index_error_d  = 1'b0;
    round_key_d    = round_key_q;
    swap_s         = shadow_full_q & (~active_valid_q | i_block_start);
    capture_s      = 1'b0;
    if (i_valid) begin
      if (i_flush) begin
        active_valid_d = 1'b0;
        shadow_full_d  = 1'b0;
      end else begin
        if (swap_s) begin
          ptr_d          = ~ptr_q;
          active_valid_d = 1'b1;
          shadow_full_d  = 1'b0;
        end else begin
          ptr_d = ptr_q;
        end
        if (i_key_ready) begin
          capture_s     = 1'b1;
          shadow_full_d = 1'b1;
          overwrite_d   = shadow_full_q & ~swap_s;
        end else begin
          capture_s = 1'b0;
        end
      end
      round_key_d   = sel_key_s;
      index_error_d = sel_range_err_s;
    end else begin
      round_key_d = round_key_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q          <= 1'b0;
      active_valid_q <= 1'b0;
      shadow_full_q  <= 1'b0;
      overwrite_q    <= 1'b0;
      index_error_q  <= 1'b0;
      round_key_q    <= {NB_RK{1'b0}};
    end else begin
      ptr_q          <= ptr_d;
      active_valid_q <= active_valid_d;
      shadow_full_q  <= shadow_full_d;
      overwrite_q    <= overwrite_d;
      index_error_q  <= index_error_d;
      round_key_q    <= round_key_d;
    end
  end

  // Bank storage is deliberately not reset; the valid flags guard its use.
  always_ff @(posedge i_clock) begin
    if (capture_s && ptr_d) begin
      bank_a_q <= i_round_key_vector;
    end else begin
      bank_a_q <= bank_a_q;
    end
    if (capture_s && !ptr_d) begin
      bank_b_q <= i_round_key_vector;
    end else begin
      bank_b_q <= bank_b_q;
    end
  end

  assign o_round_key   = round_key_q;
  assign o_key_valid   = active_valid_q;
  assign o_shadow_full = shadow_full_q;
  assign o_overwrite   = overwrite_q;
  assign o_index_error = index_error_q;

endmodule

// File: tb/tb_round_key_bank_dbuf.sv
// Table-driven bench for round_key_bank_dbuf with hand-computed expected outputs.
module tb_round_key_bank_dbuf;
  import aes_key_pkg::*;

  typedef struct packed {
    logic       valid;
    logic       rdy;
    logic       flush;
    logic       bs;
    logic [3:0] idx;
    logic [1:0] vsel;
    logic [7:0] eb;
    logic       kv;
    logic       sf;
    logic       ow;
    logic       ie;
  } step_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NB_RK_VEC-1:0]    vec = '0;
  logic                    key_ready = 1'b0, valid = 1'b0, flush = 1'b0, block_start = 1'b0;
  logic [NB_ROUND_IDX-1:0] idx = '0;
  logic [NB_RK-1:0]        rk;
  logic                    kv, sf, ow, ie;

  int checks = 0;
  int errors = 0;
  step_t tbl [27];

  round_key_bank_dbuf dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_round_key_vector (vec),
    .i_key_ready        (key_ready),
    .i_valid            (valid),
    .i_flush            (flush),
    .i_block_start      (block_start),
    .i_round_index      (idx),
    .o_round_key        (rk),
    .o_key_valid        (kv),
    .o_shadow_full      (sf),
    .o_overwrite        (ow),
    .o_index_error      (ie)
  );

  always #5 clk = ~clk;

  function automatic logic [NB_RK_VEC-1:0] mkvec(input logic [1:0] vsel);
    logic [NB_RK_VEC-1:0] v;
    logic [7:0] base;
    base = (vsel == 2'd2) ? 8'h80 : (vsel == 2'd3) ? 8'h40 : 8'h00;
    v = '0;
    for (int k = 0; k <= int'(N_ROUNDS); k++) v[k*NB_RK +: NB_RK] = {16{base | 8'(k)}};
    return v;
  endfunction

  function automatic step_t mk(input logic v, r, f, b, input logic [3:0] i, input logic [1:0] vs,
                               input logic [7:0] eb, input logic ekv, esf, eow, eie);
    step_t s;
    s.valid = v; s.rdy = r; s.flush = f; s.bs = b; s.idx = i; s.vsel = vs;
    s.eb = eb; s.kv = ekv; s.sf = esf; s.ow = eow; s.ie = eie;
    return s;
  endfunction

  task automatic chk1(input string name, input int step, input logic [NB_RK-1:0] act, input logic [NB_RK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic check_outs(input int step, input step_t s);
    chk1("round_key", step, rk, {16{s.eb}});
    chk1("key_valid", step, NB_RK'(kv), NB_RK'(s.kv));
    chk1("shadow_full", step, NB_RK'(sf), NB_RK'(s.sf));
    chk1("overwrite", step, NB_RK'(ow), NB_RK'(s.ow));
    chk1("index_error", step, NB_RK'(ie), NB_RK'(s.ie));
  endtask

  task automatic apply(input int step, input step_t s);
    @(negedge clk);
    valid = s.valid; key_ready = s.rdy; flush = s.flush; block_start = s.bs;
    idx = s.idx; vec = mkvec(s.vsel);
    @(posedge clk);
    #1;
    check_outs(step, s);
  endtask

  initial begin
    //            v     r     f     b     idx    vsel  byte   kv    sf    ow    ie
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  2'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd5,  2'd0, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  2'd0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  2'd2, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  2'd0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  2'd0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd7,  2'd0, 8'h87, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  2'd2, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  2'd3, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd1,  2'd0, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 2'd0, 8'h4E, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  2'd2, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  2'd3, 8'h82, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  2'd0, 8'h89, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd9,  2'd0, 8'h49, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  2'd0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 17; i < 22; i++)
      tbl[i] = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 2'd1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[22] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  2'd1, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[23] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  2'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[24] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[25] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  2'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[26] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd6,  2'd0, 8'h86, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state while reset is held through a clock edge.
    repeat (2) @(posedge clk);
    #1;
    check_outs(-1, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) apply(i, tbl[i]);

    // Async reset mid-block: outputs must clear before the next clock edge.
    @(negedge clk);
    valid = 1'b1; key_ready = 1'b0; flush = 1'b0; block_start = 1'b0; idx = 4'd6;
    #2 rst_n = 1'b0;
    #1;
    check_outs(100, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;

    // Recovery through a fresh cold start with V3.
    apply(101, mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    apply(102, mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 2'd0, 8'h45, 1'b1, 1'b0, 1'b0, 1'b0));
    apply(103, mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
